// File: rtl/fetch_line_buffer.sv
// Instruction fetch front end: buffers one 4-word memory line, issues its words
// through a valid/ready handshake and prefetches the following line.
module fetch_line_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   output logic [31:0]  MEM_ADDRESS,
   input  logic [127:0] MEM_LINE,
   input  logic         REDIRECT,
   input  logic [31:0]  REDIRECT_PC,
   output logic [31:0]  INSTR,
   output logic [31:0]  INSTR_PC,
   output logic         INSTR_VALID,
   input  logic         INSTR_READY
);

   typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;

   state_t       state, state_next;
   logic [29:0]  line, line_next;
   logic [1:0]   slot, slot_next;
   logic [1:0]   start_slot, start_slot_next;
   logic [127:0] buffer, buffer_next;
   logic         pf_ready, pf_ready_next;
   logic         handshake;

   assign handshake = (state == ISSUE) && INSTR_READY;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         line       <= RESET_PC[31:2];
         start_slot <= RESET_PC[1:0];
         slot       <= 2'd0;
         buffer     <= '0;
         pf_ready   <= 1'b0;
      end else begin
         state      <= state_next;
         line       <= line_next;
         start_slot <= start_slot_next;
         slot       <= slot_next;
         buffer     <= buffer_next;
         pf_ready   <= pf_ready_next;
      end
   end

   // A redirect overrides everything, including a handshake in the same cycle.
   always_comb begin
      state_next      = state;
      line_next       = line;
      start_slot_next = start_slot;
      slot_next       = slot;
      buffer_next     = buffer;
      pf_ready_next   = pf_ready;
      if (REDIRECT) begin
         line_next       = REDIRECT_PC[31:2];
         start_slot_next = REDIRECT_PC[1:0];
         pf_ready_next   = 1'b0;
         state_next      = FETCH;
      end else begin
         case (state)
            FETCH: state_next = WAIT;
            WAIT: begin
               buffer_next   = MEM_LINE;
               slot_next     = start_slot;
               pf_ready_next = 1'b0;
               state_next    = ISSUE;
            end
            ISSUE: begin
               pf_ready_next = 1'b1;
               if (handshake) begin
                  if (slot != 2'd3) begin
                     slot_next = slot + 2'd1;
                  end else if (pf_ready) begin
                     buffer_next   = MEM_LINE;
                     line_next     = line + 30'd1;
                     slot_next     = 2'd0;
                     pf_ready_next = 1'b0;
                  end else begin
                     // Prefetch not back yet: refetch the next line through WAIT.
                     line_next       = line + 30'd1;
                     start_slot_next = 2'd0;
                     pf_ready_next   = 1'b0;
                     state_next      = WAIT;
                  end
               end
            end
            default: state_next = FETCH;
         endcase
      end
   end

   assign INSTR_VALID = (state == ISSUE);
   assign MEM_ADDRESS = {2'b00, ((state == ISSUE) ? (line + 30'd1) : line)};
   assign INSTR       = INSTR_VALID ? buffer[{slot, 5'd0} +: 32] : 32'd0;
   assign INSTR_PC    = INSTR_VALID ? {line, slot} : 32'd0;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Self-checking bench for fetch_line_buffer: directed scenarios plus random
// ready/redirect traffic against a word-level issue-order model.
module tb_fetch_line_buffer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  MEM_ADDRESS;
   logic [127:0] MEM_LINE = '0;
   logic         REDIRECT = 1'b0;
   logic [31:0]  REDIRECT_PC = 32'd0;
   logic [31:0]  INSTR;
   logic [31:0]  INSTR_PC;
   logic         INSTR_VALID;
   logic         INSTR_READY = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] key = 32'd0;

   // Model: next word address to issue, invalid samples still to come, and
   // whether the current issue run has not yet seen a clock edge.
   logic [31:0] m_pc;
   int          m_gap;
   bit          m_fresh;

   fetch_line_buffer #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .MEM_ADDRESS (MEM_ADDRESS),
      .MEM_LINE    (MEM_LINE),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .INSTR       (INSTR),
      .INSTR_PC    (INSTR_PC),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] n);
      return n ^ key;
   endfunction

   function automatic logic [127:0] memLine(input logic [29:0] l);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[32*k +: 32] = memWord({l, 2'(k)});
      return r;
   endfunction

   // Synchronous instruction memory: one edge of latency.
   always @(posedge clk) MEM_LINE <= memLine(MEM_ADDRESS[29:0]);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_pc    = RESET_PC;
      m_gap   = 1;
      m_fresh = 1'b1;
   endtask

   task automatic applyStimulus(input bit rdy, input bit redir, input logic [31:0] rpc);
      bit valid;
      @(negedge clk);
      valid = (m_gap == 0);
      checkOutput("valid", 32'(INSTR_VALID), 32'(valid));
      if (valid) begin
         checkOutput("instr_pc", INSTR_PC, m_pc);
         checkOutput("instr", INSTR, memWord(m_pc));
         checkOutput("prefetch_addr", MEM_ADDRESS, {2'b00, m_pc[31:2] + 30'd1});
      end else begin
         checkOutput("fetch_addr", MEM_ADDRESS, {2'b00, m_pc[31:2]});
      end
      INSTR_READY = rdy;
      REDIRECT    = redir;
      REDIRECT_PC = rpc;
      if (redir) begin
         m_pc    = rpc;
         m_gap   = 2;
         m_fresh = 1'b1;
      end else if (!valid) begin
         m_gap--;
      end else if (rdy) begin
         // Consuming a slot-3 word on the very first issue cycle outruns the prefetch.
         if (m_fresh && m_pc[1:0] == 2'd3) begin
            m_gap   = 1;
            m_fresh = 1'b1;
         end else begin
            m_fresh = 1'b0;
         end
         m_pc = m_pc + 32'd1;
      end else begin
         m_fresh = 1'b0;
      end
   endtask

   task automatic runUntil(input logic [31:0] target);
      int n = 0;
      while (!(m_gap == 0 && m_pc == target) && n < 64) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         n++;
      end
   endtask

   initial begin
      @(negedge clk);
      checkOutput("reset_valid", 32'(INSTR_VALID), 32'd0);
      checkOutput("reset_instr", INSTR, 32'd0);
      checkOutput("reset_pc", INSTR_PC, 32'd0);
      checkOutput("reset_addr", MEM_ADDRESS, {2'b00, RESET_PC[31:2]});
      @(negedge clk);
      rst = 1'b0;
      INSTR_READY = 1'b1;
      #1;
      checkOutput("release_valid", 32'(INSTR_VALID), 32'd0);
      modelReset();

      // Straight-line issue from reset, with a 3-cycle stall on word 5.
      runUntil(32'd5);
      repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
      runUntil(32'd12);

      // Mid-line redirect.
      applyStimulus(1'b1, 1'b1, 32'h0000_001A);
      repeat (8) applyStimulus(1'b1, 1'b0, 32'd0);

      // Redirect colliding with a handshake.
      applyStimulus(1'b1, 1'b1, 32'h0000_0010);
      runUntil(32'h0000_0013);
      applyStimulus(1'b1, 1'b1, 32'h0000_0040);
      runUntil(32'h0000_0040);
      applyStimulus(1'b1, 1'b0, 32'd0);

      // Line address wrap.
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
      repeat (6) applyStimulus(1'b1, 1'b0, 32'd0);

      // Slot-3 start forces one bubble.
      applyStimulus(1'b1, 1'b1, 32'h0000_0033);
      repeat (8) applyStimulus(1'b1, 1'b0, 32'd0);

      // Asynchronous reset mid-issue.
      applyStimulus(1'b1, 1'b1, 32'h0000_0020);
      runUntil(32'h0000_0022);
      @(negedge clk);
      checkOutput("pre_reset_pc", INSTR_PC, 32'h0000_0022);
      #1 rst = 1'b1;
      #1;
      checkOutput("async_valid", 32'(INSTR_VALID), 32'd0);
      checkOutput("async_instr", INSTR, 32'd0);
      checkOutput("async_pc", INSTR_PC, 32'd0);
      checkOutput("async_addr", MEM_ADDRESS, {2'b00, RESET_PC[31:2]});
      key = $urandom;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      REDIRECT = 1'b0;
      #1;
      checkOutput("release2_valid", 32'(INSTR_VALID), 32'd0);
      modelReset();

      // Random ready/redirect traffic, biased toward the address wrap.
      for (int i = 0; i < 3000; i++) begin
         bit          rdy;
         bit          redir;
         logic [31:0] rpc;
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 15) == 0);
         rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
         applyStimulus(rdy, redir, rpc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
